// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue controller and its decoder.
package alu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned OPC_W    = 7;
  localparam int unsigned F3_W     = 3;
  localparam int unsigned F7_W     = 7;
  localparam int unsigned SHAMT_W  = 5;

  // ALU datapath operation encodings
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b1001;
  localparam logic [ALU_OP_W-1:0] ALU_PASS = 4'b1111;

  // RV32I opcodes
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

  // RV32I funct3 / funct7 values
  localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL  = 3'b001;
  localparam logic [F3_W-1:0] F3_SLT  = 3'b010;
  localparam logic [F3_W-1:0] F3_SLTU = 3'b011;
  localparam logic [F3_W-1:0] F3_XOR  = 3'b100;
  localparam logic [F3_W-1:0] F3_SR   = 3'b101;
  localparam logic [F3_W-1:0] F3_OR   = 3'b110;
  localparam logic [F3_W-1:0] F3_AND  = 3'b111;

  localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP1_ZERO = 2'd0,
    OP1_RS1  = 2'd1,
    OP1_PC   = 2'd2,
    OP1_IMM  = 2'd3
  } op1_sel_e;

  typedef enum logic [1:0] {
    OP2_ZERO = 2'd0,
    OP2_RS2  = 2'd1,
    OP2_IMM  = 2'd2
  } op2_sel_e;

  // funct3 to ALU op; alt selects SUB/SRA on the shared encodings
  function automatic logic [ALU_OP_W-1:0] f3_to_op(input logic [F3_W-1:0] f3,
                                                   input logic alt);
    logic [ALU_OP_W-1:0] op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic is_shift(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic logic is_cmp(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I integer-op decoder: fields to ALU op, operand selects, illegal flag.
module alu_decode
  import alu_pkg::*;
(
  input  logic [OPC_W-1:0]    opcode,
  input  logic [F3_W-1:0]     funct3,
  input  logic [F7_W-1:0]     funct7,
  output logic [ALU_OP_W-1:0] alu_op,
  output op1_sel_e            op1_sel,
  output op2_sel_e            op2_sel,
  output logic                illegal
);

  logic f7_base;
  logic f7_alt;

  assign f7_base = (funct7 == F7_BASE);
  assign f7_alt  = (funct7 == F7_ALT);

  // Decode; any illegal encoding collapses to ADD of zeros
  always_comb begin
    alu_op  = ALU_ADD;
    op1_sel = OP1_ZERO;
    op2_sel = OP2_ZERO;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_op  = f3_to_op(funct3, f7_alt);
        op1_sel = OP1_RS1;
        op2_sel = OP2_RS2;
        illegal = !(f7_base || (f7_alt && ((funct3 == F3_ADD) || (funct3 == F3_SR))));
      end
      OPC_OP_IMM: begin
        alu_op  = f3_to_op(funct3, f7_alt);
        op1_sel = OP1_RS1;
        op2_sel = OP2_IMM;
        illegal = !(f7_base || (f7_alt && (funct3 == F3_SR)));
      end
      OPC_LUI: begin
        alu_op  = ALU_PASS;
        op1_sel = OP1_IMM;
        op2_sel = OP2_ZERO;
      end
      OPC_AUIPC: begin
        alu_op  = ALU_ADD;
        op1_sel = OP1_PC;
        op2_sel = OP2_IMM;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      alu_op  = ALU_ADD;
      op1_sel = OP1_ZERO;
      op2_sel = OP2_ZERO;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one ALU request, drives the ALU for a cycle, returns the result.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [F3_W-1:0]     funct3,
  input  logic [F7_W-1:0]     funct7,
  input  logic [XLEN-1:0]     rs1_val,
  input  logic [XLEN-1:0]     rs2_val,
  input  logic [XLEN-1:0]     imm,
  input  logic [XLEN-1:0]     pc,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [XLEN-1:0]     alu_op1,
  output logic [XLEN-1:0]     alu_op2,
  input  logic [XLEN-1:0]     alu_res,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_res,
  output logic                out_illegal
);

  state_e              state_q;
  state_e              state_d;
  logic [ALU_OP_W-1:0] op_d;
  logic [XLEN-1:0]     op1_d;
  logic [XLEN-1:0]     op2_d;
  logic [XLEN-1:0]     res_d;
  logic                ill_d;

  logic [ALU_OP_W-1:0] dec_op;
  op1_sel_e            dec_op1_sel;
  op2_sel_e            dec_op2_sel;
  logic                dec_illegal;
  logic [XLEN-1:0]     sel_op1;
  logic [XLEN-1:0]     sel_op2;

  alu_decode u_decode (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .alu_op  (dec_op),
    .op1_sel (dec_op1_sel),
    .op2_sel (dec_op2_sel),
    .illegal (dec_illegal)
  );

  // Operand muxes; shift amounts keep only the low five bits
  always_comb begin
    sel_op1 = '0;
    sel_op2 = '0;
    case (dec_op1_sel)
      OP1_RS1: sel_op1 = rs1_val;
      OP1_PC:  sel_op1 = pc;
      OP1_IMM: sel_op1 = imm;
      default: sel_op1 = '0;
    endcase
    case (dec_op2_sel)
      OP2_RS2: sel_op2 = rs2_val;
      OP2_IMM: sel_op2 = imm;
      default: sel_op2 = '0;
    endcase
    if (is_shift(dec_op)) begin
      sel_op2 = XLEN'(sel_op2[SHAMT_W-1:0]);
    end
  end

  // Next-state and next-register values
  always_comb begin
    state_d = state_q;
    op_d    = alu_op;
    op1_d   = alu_op1;
    op2_d   = alu_op2;
    res_d   = out_res;
    ill_d   = out_illegal;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_EXEC;
          op_d    = dec_op;
          op1_d   = sel_op1;
          op2_d   = sel_op2;
          ill_d   = dec_illegal;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
        if (out_illegal) begin
          res_d = '0;
        end else if (is_cmp(alu_op)) begin
          res_d = XLEN'(alu_res[0]);
        end else begin
          res_d = alu_res;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; handshake flags follow the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      alu_op      <= ALU_ADD;
      alu_op1     <= '0;
      alu_op2     <= '0;
      out_res     <= '0;
      out_illegal <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready    <= (state_d == ST_IDLE);
      out_valid   <= (state_d == ST_RESP);
      alu_op      <= op_d;
      alu_op1     <= op1_d;
      alu_op2     <= op2_d;
      out_res     <= res_d;
      out_illegal <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU in the loop.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic [31:0] pc;
  logic [3:0]  alu_op;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [31:0] alu_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_illegal;

  int n_checks;
  int n_errors;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .imm         (imm),
    .pc          (pc),
    .alu_op      (alu_op),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_res     (alu_res),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_res     (out_res),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU datapath (full 32-bit compare results on purpose)
  always_comb begin
    case (alu_op)
      4'b0000: alu_res = alu_op1 + alu_op2;
      4'b0001: alu_res = alu_op1 - alu_op2;
      4'b0010: alu_res = alu_op1 & alu_op2;
      4'b0011: alu_res = alu_op1 | alu_op2;
      4'b0100: alu_res = alu_op1 ^ alu_op2;
      4'b0101: alu_res = alu_op1 << alu_op2[4:0];
      4'b0110: alu_res = alu_op1 >> alu_op2[4:0];
      4'b0111: alu_res = (alu_op1 < alu_op2) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
      4'b1000: alu_res = ($signed(alu_op1) < $signed(alu_op2)) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
      4'b1001: alu_res = 32'($signed(alu_op1) >>> alu_op2[4:0]);
      4'b1111: alu_res = alu_op1;
      default: alu_res = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (!in_ready && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    if (!in_ready) check({tag, "_idle_timeout"}, 32'(in_ready), 32'd1);
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [31:0] p);
    in_valid = 1'b1;
    opcode   = opc;
    funct3   = f3;
    funct7   = f7;
    rs1_val  = r1;
    rs2_val  = r2;
    imm      = im;
    pc       = p;
  endtask

  // One request; stall holds out_ready low for that many RESP cycles while junk is driven
  task automatic do_op(input string tag,
                       input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [31:0] p,
                       input logic [3:0] e_op, input logic [31:0] e_op1, input logic [31:0] e_op2,
                       input logic [31:0] e_res, input logic e_ill, input int stall);
    wait_idle(tag);
    drive(opc, f3, f7, r1, r2, im, p);
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, "_op"},  32'(alu_op), 32'(e_op));
    check({tag, "_op1"}, alu_op1, e_op1);
    check({tag, "_op2"}, alu_op2, e_op2);
    check({tag, "_vld_exec"}, 32'(out_valid), 32'd0);
    check({tag, "_rdy_exec"}, 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, out_res, e_res);
    check({tag, "_ill"}, 32'(out_illegal), 32'(e_ill));
    for (int i = 0; i < stall; i++) begin
      drive(7'b0110011, 3'b000, 7'b0100000, $urandom, $urandom, $urandom, $urandom);
      @(posedge clk);
      #1;
      check({tag, "_stall_vld"}, 32'(out_valid), 32'd1);
      check({tag, "_stall_res"}, out_res, e_res);
      check({tag, "_stall_rdy"}, 32'(in_ready), 32'd0);
      check({tag, "_stall_op"},  32'(alu_op), 32'(e_op));
      check({tag, "_stall_op1"}, alu_op1, e_op1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_rdy_done"}, 32'(in_ready), 32'd1);
    check({tag, "_vld_done"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    in_valid  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_res", out_res, 32'd0);
    check("rst_out_ill", 32'(out_illegal), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_op1", alu_op1, 32'd0);
    check("rst_alu_op2", alu_op2, 32'd0);

    do_op("sub",   7'b0110011, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'd0, 32'd0,
          4'b0001, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 0);
    do_op("slli",  7'b0010011, 3'b001, 7'b0000000, 32'd1, 32'd99, 32'h24, 32'd0,
          4'b0101, 32'd1, 32'd4, 32'h10, 1'b0, 0);
    do_op("slt",   7'b0110011, 3'b010, 7'b0000000, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0,
          4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 0);
    do_op("sltu",  7'b0110011, 3'b011, 7'b0000000, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0,
          4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0);
    do_op("load",  7'b0000011, 3'b010, 7'b0000000, 32'd11, 32'd22, 32'd33, 32'd44,
          4'b0000, 32'd0, 32'd0, 32'd0, 1'b1, 0);
    do_op("lui",   7'b0110111, 3'b000, 7'b0000000, 32'd9, 32'd9, 32'h1234_5000, 32'd0,
          4'b1111, 32'h1234_5000, 32'd0, 32'h1234_5000, 1'b0, 0);
    do_op("auipc", 7'b0010111, 3'b000, 7'b0000000, 32'd9, 32'd9, 32'h2000, 32'h1000,
          4'b0000, 32'h1000, 32'h2000, 32'h3000, 1'b0, 0);
    do_op("srai",  7'b0010011, 3'b101, 7'b0100000, 32'h8000_0000, 32'd0, 32'h404, 32'd0,
          4'b1001, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 0);
    do_op("and_f7", 7'b0110011, 3'b111, 7'b0100000, 32'hFF, 32'hF0, 32'd0, 32'd0,
          4'b0000, 32'd0, 32'd0, 32'd0, 1'b1, 0);
    do_op("addi_f7", 7'b0010011, 3'b000, 7'b0100000, 32'd3, 32'd0, 32'd4, 32'd0,
          4'b0000, 32'd0, 32'd0, 32'd0, 1'b1, 0);
    do_op("srl",   7'b0110011, 3'b101, 7'b0000000, 32'hF0, 32'h24, 32'd0, 32'd0,
          4'b0110, 32'hF0, 32'd4, 32'hF, 1'b0, 0);
    do_op("ori",   7'b0010011, 3'b110, 7'b0000000, 32'hF0, 32'd0, 32'h0F, 32'd0,
          4'b0011, 32'hF0, 32'h0F, 32'hFF, 1'b0, 0);
    do_op("xor_stall", 7'b0110011, 3'b100, 7'b0000000, 32'hFF00, 32'h0FF0, 32'd0, 32'd0,
          4'b0100, 32'hFF00, 32'h0FF0, 32'hF0F0, 1'b0, 5);

    // Reset pulse during EXEC drops the pending response
    wait_idle("rst_exec");
    drive(7'b0110011, 3'b000, 7'b0000000, 32'd100, 32'd23, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("rst_exec_op1_pre", alu_op1, 32'd100);
    rst_n = 1'b0;
    #1;
    check("rst_exec_vld", 32'(out_valid), 32'd0);
    check("rst_exec_rdy", 32'(in_ready), 32'd1);
    check("rst_exec_res", out_res, 32'd0);
    check("rst_exec_ill", 32'(out_illegal), 32'd0);
    check("rst_exec_op", 32'(alu_op), 32'd0);
    check("rst_exec_op1", alu_op1, 32'd0);
    check("rst_exec_op2", alu_op2, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rst_exec_no_vld", 32'(out_valid), 32'd0);
    end
    do_op("post_rst", 7'b0110011, 3'b000, 7'b0000000, 32'd100, 32'd23, 32'd0, 32'd0,
          4'b0000, 32'd100, 32'd23, 32'd123, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
